// File: rtl/divide_pkg.sv
// Shared core package: state encoding for the divide unit and constants used
// by the neighbouring multiply unit.
package divide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int MUL_W      = 32;
    localparam int MUL_STAGES = 3;
    localparam int MUL_PROD_W = 2 * MUL_W;

endpackage : divide_pkg

// File: rtl/divide.sv
// Iterative restoring divider, signed or unsigned, fixed W+2 cycle latency
// from accepted stb to the ack pulse.
module divide
    import divide_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    input  logic         stb,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         ack
);

    localparam int CTR_W = $clog2(W);

    div_state_e         state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       q_q, q_d;
    logic [W-1:0]       r_q, r_d;
    logic               ack_q, ack_d;

    logic [W-1:0]       b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               a_neg_q, a_neg_d;
    logic [W-1:0]       dvd_q, dvd_d;
    logic [W-1:0]       rem_q, rem_d;

    logic               load_s, step_s, fix_s;
    logic               a_in_neg_s;
    logic [W-1:0]       a_in_mag_s;
    logic               b_neg_s;
    logic [W:0]         b_ext_s, b_mag_s;
    logic [W:0]         trial_s;
    logic               ge_s;
    logic [W-1:0]       q_fix_s, r_fix_s;

    // Dividend magnitude at capture; W-bit unsigned negation of the most
    // negative value yields exactly 2^(W-1), so no extra bit is needed here.
    always_comb begin
        a_in_neg_s = is_signed & a[W-1];
        if (a_in_neg_s) begin
            a_in_mag_s = ~a + W'(1);
        end else begin
            a_in_mag_s = a;
        end
    end

    // Divisor magnitude and one restoring step, all in W+1 bits.
    always_comb begin
        b_neg_s = sgn_q & b_q[W-1];
        b_ext_s = {b_neg_s, b_q};
        if (b_neg_s) begin
            b_mag_s = ~b_ext_s + (W+1)'(1);
        end else begin
            b_mag_s = b_ext_s;
        end
        trial_s = {rem_q, dvd_q[W-1]};
        ge_s    = (trial_s >= b_mag_s);
    end

    // Sign correction of the final magnitudes; b == 0 forces an all-ones quotient.
    always_comb begin
        if (b_q == {W{1'b0}}) begin
            q_fix_s = {W{1'b1}};
        end else if (a_neg_q ^ b_neg_s) begin
            q_fix_s = ~dvd_q + W'(1);
        end else begin
            q_fix_s = dvd_q;
        end
        if (a_neg_q) begin
            r_fix_s = ~rem_q + W'(1);
        end else begin
            r_fix_s = rem_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (stb) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == {CTR_W{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        fix_s  = 1'b0;
        case (state_q)
            IDLE:    load_s = stb;
            RUN:     step_s = 1'b1;
            FIX:     fix_s  = 1'b1;
            default: begin
                load_s = 1'b0;
                step_s = 1'b0;
                fix_s  = 1'b0;
            end
        endcase
    end

    // Next values for the counter and the result registers.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        r_d   = r_q;
        ack_d = fix_s;
        if (load_s) begin
            cnt_d = CTR_W'(W - 1);
        end else if (step_s && (cnt_q != {CTR_W{1'b0}})) begin
            cnt_d = cnt_q - CTR_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (fix_s) begin
            q_d = q_fix_s;
            r_d = r_fix_s;
        end else begin
            q_d = q_q;
            r_d = r_q;
        end
    end

    // Next values for operand capture and the shifting datapath.
    always_comb begin
        b_d     = b_q;
        sgn_d   = sgn_q;
        a_neg_d = a_neg_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        if (load_s) begin
            b_d     = b;
            sgn_d   = is_signed;
            a_neg_d = a_in_neg_s;
            dvd_d   = a_in_mag_s;
            rem_d   = {W{1'b0}};
        end else if (step_s) begin
            dvd_d = {dvd_q[W-2:0], ge_s};
            if (ge_s) begin
                rem_d = trial_s[W-1:0] - b_mag_s[W-1:0];
            end else begin
                rem_d = trial_s[W-1:0];
            end
        end else begin
            dvd_d = dvd_q;
            rem_d = rem_q;
        end
    end

    // Control and result registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CTR_W{1'b0}};
            q_q   <= {W{1'b0}};
            r_q   <= {W{1'b0}};
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
            r_q   <= r_d;
            ack_q <= ack_d;
        end
    end

    // Operand and partial-remainder registers are don't-care in IDLE, so no reset.
    always_ff @(posedge clk) begin
        b_q     <= b_d;
        sgn_q   <= sgn_d;
        a_neg_q <= a_neg_d;
        dvd_q   <= dvd_d;
        rem_q   <= rem_d;
    end

    assign q   = q_q;
    assign r   = r_q;
    assign ack = ack_q;

endmodule : divide

// File: tb/tb_divide.sv
// Directed-vector bench for the divide unit: table of operations plus
// busy, back-to-back and mid-operation reset sequences.
module tb_divide;

    localparam int W   = 32;
    localparam int LAT = 34;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] eq;
        logic [W-1:0] er;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         is_signed;
    logic         stb;
    logic [W-1:0] q, r;
    logic         ack;

    int checks   = 0;
    int failures = 0;

    divide #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .stb       (stb),
        .q         (q),
        .r         (r),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        @(negedge clk);
        a         = av;
        b         = bv;
        is_signed = sv;
        stb       = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
    endtask

    // Counts falling edges until ack is seen; 100 means it never came.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 100);
    endtask

    vec_t vecs[13];
    int   n, n2;
    bit   seen;

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{32'h12345678,   32'h0,          1'b0, 32'hFFFFFFFF,   32'h12345678};
        vecs[3]  = '{32'h12345678,   32'h0,          1'b1, 32'hFFFFFFFF,   32'h12345678};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'h0};
        vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'h0,          32'h80000000};
        vecs[6]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
        vecs[7]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF};
        vecs[8]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'h0};
        vecs[9]  = '{32'hFFFFFFFF,   32'd16,         1'b0, 32'h0FFFFFFF,   32'hF};
        vecs[10] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0};
        vecs[11] = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE};
        vecs[12] = '{32'h80000000,   32'd2,          1'b1, 32'hC0000000,   32'h0};

        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        stb       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_q", q, 32'd0);
        check("reset_r", r, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_ack(n);
            check($sformatf("latency[%0d]", i), n, LAT);
            check($sformatf("q[%0d]", i), q, vecs[i].eq);
            check($sformatf("r[%0d]", i), r, vecs[i].er);
            @(negedge clk);
            check($sformatf("ack_pulse[%0d]", i), {31'd0, ack}, 32'd0);
        end

        // stb mid-RUN with other operands must be ignored
        start_op(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        a = 32'd555; b = 32'd3; is_signed = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        wait_ack(n);
        check("busy_latency", n + 6, LAT);
        check("busy_q", q, 32'd14);
        check("busy_r", r, 32'd2);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("busy_no_second_ack", {31'd0, seen}, 32'd0);

        // stb held high in the ack cycle starts the next operation
        start_op(32'd100, 32'd7, 1'b0);
        wait_ack(n);
        check("b2b_first_latency", n, LAT);
        check("b2b_first_q", q, 32'd14);
        a = 32'hFFFFFFF9; b = 32'd2; is_signed = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        wait_ack(n2);
        check("b2b_second_latency", n2, LAT);
        check("b2b_second_q", q, 32'hFFFFFFFD);
        check("b2b_second_r", r, 32'hFFFFFFFF);

        // reset during RUN abandons the operation
        start_op(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_q", q, 32'd0);
        check("rst_mid_r", r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("rst_no_ack", {31'd0, seen}, 32'd0);
        start_op(32'd100, 32'd7, 1'b0);
        wait_ack(n);
        check("post_rst_latency", n, LAT);
        check("post_rst_q", q, 32'd14);
        check("post_rst_r", r, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_divide

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand and result width in bits.
REQ-002 SHALL have localparam CTR_W, default $clog2(W), meaning iteration counter width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port a  input  W  meaning dividend.
REQ-006 SHALL have port b  input  W  meaning divisor.
REQ-007 SHALL have port is_signed  input  1  meaning operands and results are two's complement when high, unsigned when low.
REQ-008 SHALL have port stb  input  1  meaning start request.
REQ-009 SHALL have port q  output  W  meaning quotient.
REQ-010 SHALL have port r  output  W  meaning remainder.
REQ-011 SHALL have port ack  output  1  meaning one-cycle completion pulse with q and r valid.

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN, FIX.
REQ-013 SHALL, in IDLE with stb high at a rising edge, capture a, b and is_signed, load counter with W-1, clear the partial remainder, and enter RUN.
REQ-014 SHALL ignore stb while in RUN or FIX; the captured operands do not change mid-operation.
REQ-015 SHALL perform, in RUN, one restoring-division step per cycle on operand magnitudes: shift the partial remainder left by one, bring in the next dividend MSB, subtract |b| if the result is >= |b|, and shift the quotient bit in.
REQ-016 SHALL decrement the counter each RUN cycle and enter FIX on the edge where the counter is 0 (W RUN cycles).
REQ-017 SHALL, in FIX, write q and r with sign correction: q negated when sign(a) XOR sign(b) in signed mode, r negated when sign(a) in signed mode; then assert ack for exactly one cycle and return to IDLE.
REQ-018 SHALL, when b == 0, produce q = all ones and r = a, in both modes.
REQ-019 SHALL, in signed mode with a = most negative value and b = -1, produce q = a and r = 0.
REQ-020 SHALL give a fixed latency: when stb is accepted at edge N, ack is high during the cycle after edge N+W+1. Special cases SHALL NOT use a fast path.
REQ-021 SHALL hold q and r stable from the FIX write until the next FIX write.
REQ-022 SHALL accept an stb that is high in the same cycle ack is high, because the block is in IDLE then; this gives back-to-back operation.
REQ-023 SHALL compute magnitudes in W+1-bit arithmetic so that |most negative| does not overflow.
REQ-024 SHALL place every result bit so that it satisfies a = q*b + r (mod 2^W), with sign(r) = sign(a) or r = 0.

Reset
REQ-025 SHALL, while rst_n is low, force the state to IDLE and set ack, q, r and the counter to 0, independent of clk.
REQ-026 SHALL, when reset is asserted during RUN or FIX, abandon the operation with no ack; the first stb after release starts a fresh operation.
REQ-027 SHALL leave the operand capture and partial remainder registers without reset; they are don't-care in IDLE.

Structure
REQ-028 SHALL define the state enum div_state_e (IDLE, RUN, FIX) in the shared core package, alongside multiply-unit constants.
REQ-029 SHALL be a single module with no sub-module; magnitude and negation logic is inline.

Verification
REQ-030 SHALL cover unsigned division: W=32, a=100, b=7, is_signed=0, stb at edge N -> q=14, r=2, ack high only in the cycle after edge N+33.
REQ-031 SHALL cover signed division: a=0xFFFFFFF9 (-7), b=2, is_signed=1 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
REQ-032 SHALL cover divide by zero: a=0x12345678, b=0, once with is_signed=0 and once with is_signed=1 -> q=0xFFFFFFFF, r=0x12345678 both times.
REQ-033 SHALL cover signed overflow: a=0x80000000, b=0xFFFFFFFF, is_signed=1 -> q=0x80000000, r=0.
REQ-034 SHALL cover busy and back-to-back behaviour: stb pulsed mid-RUN with different operands -> result of the first operation only; stb held high during the ack cycle -> second operation starts and its ack arrives 34 cycles later.
REQ-035 SHALL cover reset mid-operation: rst_n low for one cycle at RUN cycle 10 -> ack, q and r are 0 immediately, no ack follows, and a later 100/7 returns q=14, r=2.
